// File: rtl/rocc_cmd_ctrl_if.sv
// Bundle of RoCC issue, accelerator command/response and scoreboard writeback signals.
// Directions in signal names are from the controller's point of view (slave modport).
interface rocc_cmd_ctrl_if #(
    parameter int TRANS_ID_BITS = 3
);
    logic                     rocc_valid_i;
    logic                     rocc_ready_o;
    logic [31:0]              rocc_instr_i;
    logic [63:0]              rs1_i;
    logic [63:0]              rs2_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;

    logic                     cmd_valid_o;
    logic                     cmd_ready_i;
    logic [31:0]              cmd_instr_o;
    logic [63:0]              cmd_rs1_o;
    logic [63:0]              cmd_rs2_o;

    logic                     resp_valid_i;
    logic                     resp_ready_o;
    logic [63:0]              resp_data_i;

    logic                     wb_valid_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [63:0]              wb_data_o;

    modport slave (
        input  rocc_valid_i, rocc_instr_i, rs1_i, rs2_i, trans_id_i,
        input  cmd_ready_i, resp_valid_i, resp_data_i,
        output rocc_ready_o, cmd_valid_o, cmd_instr_o, cmd_rs1_o, cmd_rs2_o,
        output resp_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o
    );

    modport master (
        output rocc_valid_i, rocc_instr_i, rs1_i, rs2_i, trans_id_i,
        output cmd_ready_i, resp_valid_i, resp_data_i,
        input  rocc_ready_o, cmd_valid_o, cmd_instr_o, cmd_rs1_o, cmd_rs2_o,
        input  resp_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o
    );
endinterface

// File: rtl/rocc_cmd_ctrl.sv
// RoCC command sequencer: one-entry command register, outstanding trans_id FIFO
// and a single writeback port back to the scoreboard.
module rocc_cmd_ctrl #(
    parameter int NR_OUTSTANDING = 4,
    parameter int TRANS_ID_BITS  = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                busy_o,
    rocc_cmd_ctrl_if.slave      bus
);
    localparam int PTR_W = $clog2(NR_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   r_state;
    logic                     r_cmd_valid;
    logic [31:0]              r_instr;
    logic [63:0]              r_rs1;
    logic [63:0]              r_rs2;
    logic [TRANS_ID_BITS-1:0] r_tid;
    logic                     r_xd;

    logic [TRANS_ID_BITS-1:0] r_fifo_id [NR_OUTSTANDING];
    logic [NR_OUTSTANDING-1:0] r_fifo_kill;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic                     r_pend;
    logic [TRANS_ID_BITS-1:0] r_pend_id;

    logic                     r_wb_valid;
    logic [TRANS_ID_BITS-1:0] r_wb_id;
    logic [63:0]              r_wb_data;

    logic w_fifo_empty, w_ready, w_accept, w_sent, w_push, w_pop;
    logic w_head_kill, w_wb_resp, w_wb_pend;
    logic [TRANS_ID_BITS-1:0] w_head_id;

    always_comb begin
        w_fifo_empty = (r_count == '0);
        w_ready      = (r_state == IDLE) &&
                       ((r_count + CNT_W'(r_pend)) < CNT_W'(NR_OUTSTANDING)) && !flush_i;
        w_accept     = bus.rocc_valid_i && w_ready;
        w_sent       = r_cmd_valid && bus.cmd_ready_i;
        w_push       = w_sent && r_xd;
        w_pop        = bus.resp_valid_i && !w_fifo_empty;
        w_head_id    = r_fifo_id[r_rd_ptr];
        w_head_kill  = r_fifo_kill[r_rd_ptr];
        // Response writebacks win the port; the no-xd slot waits for a free cycle.
        w_wb_resp    = w_pop && !w_head_kill && !flush_i;
        w_wb_pend    = r_pend && !w_wb_resp && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
            r_instr     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_tid       <= '0;
            r_xd        <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_id   <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_id     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_wb_resp) begin
                r_wb_valid <= 1'b1;
                r_wb_id    <= w_head_id;
                r_wb_data  <= bus.resp_data_i;
            end else if (w_wb_pend) begin
                r_wb_valid <= 1'b1;
                r_wb_id    <= r_pend_id;
                r_wb_data  <= '0;
            end

            if (flush_i || w_wb_pend) r_pend <= 1'b0;
            if (w_sent && !r_xd && !flush_i) begin
                r_pend    <= 1'b1;
                r_pend_id <= r_tid;
            end

            case (r_state)
                IDLE: if (w_accept) begin
                    r_state     <= SEND;
                    r_cmd_valid <= 1'b1;
                    r_instr     <= bus.rocc_instr_i;
                    r_rs1       <= bus.rs1_i;
                    r_rs2       <= bus.rs2_i;
                    r_tid       <= bus.trans_id_i;
                    r_xd        <= bus.rocc_instr_i[14];
                end
                SEND: if (w_sent || flush_i) begin
                    r_state     <= IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_id   <= '{default: '0};
            r_fifo_kill <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            // A push in the flush cycle lands after the bulk kill, so it is written killed too.
            if (flush_i) r_fifo_kill <= '1;
            if (w_push) begin
                r_fifo_id[r_wr_ptr]   <= r_tid;
                r_fifo_kill[r_wr_ptr] <= flush_i;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rocc_ready_o  = w_ready;
    assign bus.cmd_valid_o   = r_cmd_valid;
    assign bus.cmd_instr_o   = r_instr;
    assign bus.cmd_rs1_o     = r_rs1;
    assign bus.cmd_rs2_o     = r_rs2;
    assign bus.resp_ready_o  = !w_fifo_empty;
    assign bus.wb_valid_o    = r_wb_valid;
    assign bus.wb_trans_id_o = r_wb_id;
    assign bus.wb_data_o     = r_wb_data;
    assign busy_o            = (r_state == SEND) || !w_fifo_empty || r_pend;
endmodule

// File: tb/tb_rocc_cmd_ctrl.sv
// Bench for rocc_cmd_ctrl: vector table, directed corner sequences, then random
// traffic against a queue-based reference model.
module tb_rocc_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rocc_cmd_ctrl_if #(.TRANS_ID_BITS(3)) bus ();

    rocc_cmd_ctrl #(.NR_OUTSTANDING(4), .TRANS_ID_BITS(3)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .busy_o  (busy),
        .bus     (bus)
    );

    typedef struct {
        logic        rv;
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  tid;
        logic        cready;
        logic        rvalid;
        logic [63:0] rdata;
        logic        fl;
        logic        e_ready;
        logic        e_cv;
        logic        e_rr;
        logic        e_wbv;
        logic [2:0]  e_wbid;
        logic [63:0] e_wbd;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [2:0] id;
        logic       kill;
    } ent_t;

    // reference model state
    ent_t        mq[$];
    bit          m_send, m_xd, m_pend, m_wbv, prev_rv;
    logic [31:0] m_instr;
    logic [63:0] m_rs1, m_rs2, m_wbd;
    logic [2:0]  m_tid, m_pid, m_wbid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.rocc_valid_i = 1'b0;
        bus.rocc_instr_i = '0;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
        bus.trans_id_i   = '0;
        bus.cmd_ready_i  = 1'b0;
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = '0;
        flush            = 1'b0;
    endtask

    // Accept then send one command; returns at the negedge after the send cycle.
    task automatic issue(input logic [2:0] tid, input bit xd);
        @(negedge clk);
        bus.rocc_valid_i = 1'b1;
        bus.rocc_instr_i = xd ? 32'h0000_600B : 32'h0000_200B;
        bus.trans_id_i   = tid;
        bus.rs1_i        = 64'(tid) + 64'h100;
        #1 chk("issue_ready", bus.rocc_ready_o, 1'b1);
        @(negedge clk);
        bus.rocc_valid_i = 1'b0;
        bus.cmd_ready_i  = 1'b1;
        #1 chk("issue_cvalid", bus.cmd_valid_o, 1'b1);
        @(negedge clk);
        bus.cmd_ready_i  = 1'b0;
    endtask

    task automatic respond(input logic [63:0] data, input bit exp_wb, input logic [2:0] exp_id);
        @(negedge clk);
        bus.resp_valid_i = 1'b1;
        bus.resp_data_i  = data;
        #1 chk("resp_ready", bus.resp_ready_o, 1'b1);
        @(negedge clk);
        bus.resp_valid_i = 1'b0;
        #1 chk("resp_wbv", bus.wb_valid_o, exp_wb);
        if (exp_wb) begin
            chk("resp_wbid", bus.wb_trans_id_o, exp_id);
            chk("resp_wbd", bus.wb_data_o, data);
        end
    endtask

    task automatic model_check();
        bit e_ready;
        e_ready = !m_send && (mq.size() + int'(m_pend)) < 4 && !flush;
        chk("m_ready", bus.rocc_ready_o, e_ready);
        chk("m_cv", bus.cmd_valid_o, m_send);
        chk("m_rr", bus.resp_ready_o, mq.size() != 0);
        chk("m_busy", busy, m_send || mq.size() != 0 || m_pend);
        chk("m_wbv", bus.wb_valid_o, m_wbv);
        if (m_send) begin
            chk("m_instr", bus.cmd_instr_o, m_instr);
            chk("m_rs1", bus.cmd_rs1_o, m_rs1);
            chk("m_rs2", bus.cmd_rs2_o, m_rs2);
        end
        if (m_wbv) begin
            chk("m_wbid", bus.wb_trans_id_o, m_wbid);
            chk("m_wbd", bus.wb_data_o, m_wbd);
        end
    endtask

    task automatic model_step();
        bit   acc, sent, pop;
        ent_t h;
        acc  = !m_send && (mq.size() + int'(m_pend)) < 4 && !flush && bus.rocc_valid_i;
        sent = m_send && bus.cmd_ready_i;
        pop  = bus.resp_valid_i && mq.size() != 0;
        h    = '{3'd0, 1'b1};
        if (pop) h = mq.pop_front();
        m_wbv = 1'b0;
        if (!flush && pop && !h.kill) begin
            m_wbv = 1'b1; m_wbid = h.id; m_wbd = bus.resp_data_i;
        end else if (!flush && m_pend) begin
            m_wbv = 1'b1; m_wbid = m_pid; m_wbd = '0; m_pend = 1'b0;
        end
        if (flush) begin
            m_pend = 1'b0;
            foreach (mq[k]) mq[k].kill = 1'b1;
        end
        if (sent && m_xd) mq.push_back('{m_tid, flush});
        else if (sent && !flush) begin
            m_pend = 1'b1; m_pid = m_tid;
        end
        if (acc) begin
            m_send  = 1'b1;
            m_instr = bus.rocc_instr_i;
            m_rs1   = bus.rs1_i;
            m_rs2   = bus.rs2_i;
            m_tid   = bus.trans_id_i;
            m_xd    = bus.rocc_instr_i[14];
        end else if (sent || flush) begin
            m_send = 1'b0;
        end
        prev_rv = bus.resp_valid_i;
    endtask

    initial begin
        vec_t        tbl[13];
        vec_t        last;
        logic [31:0] hold_instr;

        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_cv", bus.cmd_valid_o, 1'b0);
        chk("rst_wbv", bus.wb_valid_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_instr", bus.cmd_instr_o, 32'h0);
        chk("rst_wbd", bus.wb_data_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", bus.rocc_ready_o, 1'b1);

        // single xd command, then a no-xd command colliding with a response writeback
        tbl[0]  = '{1, 32'h600B, 64'd5,    64'd7,    3'd2, 0, 0, 64'h0,    0, 1, 0, 0, 0, 3'd0, 64'h0,    0};
        tbl[1]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 1, 0, 64'h0,    0, 0, 1, 0, 0, 3'd0, 64'h0,    1};
        tbl[2]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 1, 0, 3'd0, 64'h0,    1};
        tbl[3]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 1, 64'hCAFE, 0, 1, 0, 1, 0, 3'd0, 64'h0,    1};
        tbl[4]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 0, 1, 3'd2, 64'hCAFE, 0};
        tbl[5]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 0, 0, 3'd0, 64'h0,    0};
        tbl[6]  = '{1, 32'h600B, 64'h11,   64'h22,   3'd1, 0, 0, 64'h0,    0, 1, 0, 0, 0, 3'd0, 64'h0,    0};
        tbl[7]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 1, 0, 64'h0,    0, 0, 1, 0, 0, 3'd0, 64'h0,    1};
        tbl[8]  = '{1, 32'h200B, 64'h33,   64'h44,   3'd5, 0, 0, 64'h0,    0, 1, 0, 1, 0, 3'd0, 64'h0,    1};
        tbl[9]  = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 1, 1, 64'h1234, 0, 0, 1, 1, 0, 3'd0, 64'h0,    1};
        tbl[10] = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 0, 1, 3'd1, 64'h1234, 1};
        tbl[11] = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 0, 1, 3'd5, 64'h0,    0};
        tbl[12] = '{0, 32'h0,    64'd0,    64'd0,    3'd0, 0, 0, 64'h0,    0, 1, 0, 0, 0, 3'd0, 64'h0,    0};
        last = tbl[0];
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.rocc_valid_i = tbl[i].rv;
            bus.rocc_instr_i = tbl[i].instr;
            bus.rs1_i        = tbl[i].rs1;
            bus.rs2_i        = tbl[i].rs2;
            bus.trans_id_i   = tbl[i].tid;
            bus.cmd_ready_i  = tbl[i].cready;
            bus.resp_valid_i = tbl[i].rvalid;
            bus.resp_data_i  = tbl[i].rdata;
            flush            = tbl[i].fl;
            #1;
            chk($sformatf("v%0d_ready", i), bus.rocc_ready_o, tbl[i].e_ready);
            chk($sformatf("v%0d_cv", i), bus.cmd_valid_o, tbl[i].e_cv);
            chk($sformatf("v%0d_rr", i), bus.resp_ready_o, tbl[i].e_rr);
            chk($sformatf("v%0d_wbv", i), bus.wb_valid_o, tbl[i].e_wbv);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_wbv) begin
                chk($sformatf("v%0d_wbid", i), bus.wb_trans_id_o, tbl[i].e_wbid);
                chk($sformatf("v%0d_wbd", i), bus.wb_data_o, tbl[i].e_wbd);
            end
            if (tbl[i].e_cv) begin
                chk($sformatf("v%0d_instr", i), bus.cmd_instr_o, last.instr);
                chk($sformatf("v%0d_rs1", i), bus.cmd_rs1_o, last.rs1);
                chk($sformatf("v%0d_rs2", i), bus.cmd_rs2_o, last.rs2);
            end
            if (tbl[i].rv && tbl[i].e_ready) last = tbl[i];
        end
        idle_inputs();

        // backpressure: accelerator stalls 5 cycles while issue keeps offering another command
        @(negedge clk);
        bus.rocc_valid_i = 1'b1;
        bus.rocc_instr_i = 32'h0000_700B;
        bus.rs1_i        = 64'hAAAA;
        bus.rs2_i        = 64'hBBBB;
        bus.trans_id_i   = 3'd3;
        hold_instr       = bus.rocc_instr_i;
        @(negedge clk);
        bus.rocc_instr_i = 32'h0000_600B;
        bus.rs1_i        = 64'h1;
        bus.trans_id_i   = 3'd6;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_cv", bus.cmd_valid_o, 1'b1);
            chk("bp_ready", bus.rocc_ready_o, 1'b0);
            chk("bp_instr", bus.cmd_instr_o, hold_instr);
            chk("bp_rs1", bus.cmd_rs1_o, 64'hAAAA);
            chk("bp_rs2", bus.cmd_rs2_o, 64'hBBBB);
            @(negedge clk);
        end
        bus.rocc_valid_i = 1'b0;
        bus.cmd_ready_i  = 1'b1;
        #1 chk("bp_cv6", bus.cmd_valid_o, 1'b1);
        @(negedge clk);
        bus.cmd_ready_i  = 1'b0;
        #1 chk("bp_cv_drop", bus.cmd_valid_o, 1'b0);
        respond(64'hBEEF, 1'b1, 3'd3);

        // fill the FIFO, then drain in order
        for (int i = 0; i < 4; i++) issue(3'(i), 1'b1);
        #1 chk("fill_ready", bus.rocc_ready_o, 1'b0);
        respond(64'h1000, 1'b1, 3'd0);
        chk("fill_ready_back", bus.rocc_ready_o, 1'b1);
        for (int i = 1; i < 4; i++) respond(64'h1000 + 64'(i), 1'b1, 3'(i));
        chk("fill_busy", busy, 1'b0);

        // flush with two outstanding and one stalled in SEND
        issue(3'd4, 1'b1);
        issue(3'd5, 1'b1);
        @(negedge clk);
        bus.rocc_valid_i = 1'b1;
        bus.trans_id_i   = 3'd6;
        bus.rocc_instr_i = 32'h0000_600B;
        @(negedge clk);
        bus.rocc_valid_i = 1'b0;
        #1 chk("fl_cv_pre", bus.cmd_valid_o, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_ready", bus.rocc_ready_o, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fl_cv", bus.cmd_valid_o, 1'b0);
        chk("fl_busy", busy, 1'b1);
        respond(64'h4444, 1'b0, 3'd0);
        respond(64'h5555, 1'b0, 3'd0);
        chk("fl_busy_end", busy, 1'b0);
        chk("fl_rr_end", bus.resp_ready_o, 1'b0);
        issue(3'd7, 1'b1);
        respond(64'h7777, 1'b1, 3'd7);

        // asynchronous reset mid-SEND
        issue(3'd1, 1'b1);
        issue(3'd2, 1'b1);
        @(negedge clk);
        bus.rocc_valid_i = 1'b1;
        bus.trans_id_i   = 3'd3;
        @(negedge clk);
        bus.rocc_valid_i = 1'b0;
        #1 chk("ar_cv_pre", bus.cmd_valid_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_cv", bus.cmd_valid_o, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_rr", bus.resp_ready_o, 1'b0);
        chk("ar_wbv", bus.wb_valid_o, 1'b0);
        chk("ar_instr", bus.cmd_instr_o, 32'h0);
        chk("ar_rs1", bus.cmd_rs1_o, 64'h0);
        chk("ar_wbd", bus.wb_data_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_ready", bus.rocc_ready_o, 1'b1);

        // random traffic against the reference model
        mq.delete();
        m_send = 0; m_xd = 0; m_pend = 0; m_wbv = 0; prev_rv = 0;
        m_instr = '0; m_rs1 = '0; m_rs2 = '0; m_wbd = '0;
        m_tid = '0; m_pid = '0; m_wbid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.rocc_valid_i = 1'($urandom_range(0, 1));
            bus.rocc_instr_i = $urandom;
            bus.rs1_i        = {$urandom, $urandom};
            bus.rs2_i        = {$urandom, $urandom};
            bus.trans_id_i   = 3'($urandom_range(0, 7));
            bus.cmd_ready_i  = 1'($urandom_range(0, 1));
            bus.resp_valid_i = prev_rv ? 1'b0 : 1'($urandom_range(0, 1));
            bus.resp_data_i  = {$urandom, $urandom};
            flush            = ($urandom_range(0, 19) == 0);
            #1 model_check();
            @(posedge clk);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
